// File: rtl/exc_pkg.sv
// Shared constants for the MIPS-32 exception controller: exception codes, CP0 register
// numbers, Status/Cause bit positions and the priority encoder.
package exc_pkg;

    typedef enum logic {StRun, StFlush} exc_state_e;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

    localparam logic [31:0] CODE_NONE = 32'h00;
    localparam logic [31:0] CODE_INT  = 32'h01;
    localparam logic [31:0] CODE_ADEL = 32'h04;
    localparam logic [31:0] CODE_ADES = 32'h05;
    localparam logic [31:0] CODE_SYS  = 32'h08;
    localparam logic [31:0] CODE_BP   = 32'h09;
    localparam logic [31:0] CODE_RI   = 32'h0a;
    localparam logic [31:0] CODE_OV   = 32'h0c;
    localparam logic [31:0] CODE_ERET = 32'h0e;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam int unsigned ST_IE     = 0;
    localparam int unsigned ST_EXL    = 1;
    localparam int unsigned ST_IM_LO  = 8;
    localparam int unsigned CA_EXC_LO = 2;
    localparam int unsigned CA_IP_LO  = 8;
    localparam int unsigned CA_BD     = 31;

    // vec = {overflow, invalid, eret, break, syscall, ades, adel}; first match wins.
    function automatic logic [31:0] exc_encode(input logic valid, input logic irq,
                                               input logic [6:0] vec);
        logic [31:0] code;
        code = CODE_NONE;
        if (valid) begin
            if (irq)         code = CODE_INT;
            else if (vec[0]) code = CODE_ADEL;
            else if (vec[1]) code = CODE_ADES;
            else if (vec[2]) code = CODE_SYS;
            else if (vec[3]) code = CODE_BP;
            else if (vec[4]) code = CODE_ERET;
            else if (vec[5]) code = CODE_RI;
            else if (vec[6]) code = CODE_OV;
        end
        return code;
    endfunction

endpackage

// File: rtl/exc_sync2.sv
// Two-flop synchroniser for level-sensitive asynchronous inputs.
module exc_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/exc_ctrl.sv
// MEM/WB exception and interrupt controller: prioritises events, owns the exception CP0
// registers and issues a registered one-cycle flush with its redirect PC.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int unsigned       NUM_HW_INT = 6,
    parameter bit                TIMER_EN   = 1'b1,
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(EXC_VECTOR_DEF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  mem_valid,
    input  logic [ADDR_W-1:0]     mem_pc,
    input  logic                  mem_bd,
    input  logic [ADDR_W-1:0]     mem_badaddr,
    input  logic [6:0]            exc_vec,
    input  logic [NUM_HW_INT-1:0] hw_int,
    input  logic                  cp0_we,
    input  logic [4:0]            cp0_addr,
    input  logic [31:0]           cp0_wdata,
    output logic [31:0]           cp0_rdata,
    output logic [31:0]           excepttype,
    output logic                  flush,
    output logic [ADDR_W-1:0]     redirect_pc,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o
);

    logic [NUM_HW_INT-1:0] hw_sync;

    exc_sync2 #(.WIDTH(NUM_HW_INT)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .async_i(hw_int),
        .sync_o (hw_sync)
    );

    exc_state_e        state_q, state_d;
    logic              flush_q, flush_d;
    logic [ADDR_W-1:0] redirect_q, redirect_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [ADDR_W-1:0] badvaddr_q, badvaddr_d;
    logic [31:0]       status_q, status_d;
    logic [31:0]       count_q, count_d;
    logic [31:0]       compare_q, compare_d;
    logic [4:0]        exc_code_q, exc_code_d;
    logic [1:0]        ip_sw_q, ip_sw_d;
    logic              bd_q, bd_d;
    logic              timer_q, timer_d;
    logic              tick_q, tick_d;

    logic [5:0]  ip_hw;
    logic [7:0]  ip;
    logic [31:0] cause;
    logic        irq;
    logic        commit;

    // Hardware IP bits are live from the synchroniser, so they are read-only to MTC0.
    always_comb begin
        ip_hw = '0;
        ip_hw[NUM_HW_INT-1:0] = hw_sync;
        ip_hw[5] = ip_hw[5] | (TIMER_EN & timer_q);
    end

    assign ip    = {ip_hw, ip_sw_q};
    assign cause = {bd_q, 15'b0, ip, 1'b0, exc_code_q, 2'b0};
    assign irq   = (|(ip & status_q[ST_IM_LO +: 8])) && !status_q[ST_EXL] && status_q[ST_IE];

    assign excepttype = exc_encode(mem_valid && (state_q == StRun), irq, exc_vec);
    assign commit     = (excepttype != CODE_NONE) && !stall;

    always_comb begin
        state_d    = StRun;
        flush_d    = 1'b0;
        redirect_d = redirect_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        status_d   = status_q;
        compare_d  = compare_q;
        exc_code_d = exc_code_q;
        ip_sw_d    = ip_sw_q;
        bd_d       = bd_q;
        tick_d     = ~tick_q;
        count_d    = tick_q ? count_q + 32'd1 : count_q;
        timer_d    = timer_q;
        // Match is taken as Count steps onto Compare, so the reset state 0 == 0 stays quiet.
        if (tick_q && (count_q + 32'd1 == compare_q)) timer_d = 1'b1;

        if (commit) begin
            state_d = StFlush;
            flush_d = 1'b1;
            if (excepttype == CODE_ERET) begin
                status_d[ST_EXL] = 1'b0;
                redirect_d       = epc_q;
            end else begin
                exc_code_d = (excepttype == CODE_INT) ? 5'd0 : excepttype[4:0];
                if (!status_q[ST_EXL]) begin
                    epc_d = mem_bd ? mem_pc - ADDR_W'(4) : mem_pc;
                    bd_d  = mem_bd;
                end
                status_d[ST_EXL] = 1'b1;
                if (excepttype == CODE_ADEL || excepttype == CODE_ADES) badvaddr_d = mem_badaddr;
                redirect_d = EXC_VECTOR;
            end
        end else if (cp0_we) begin
            case (cp0_addr)
                CP0_COUNT: begin
                    count_d = cp0_wdata;
                    tick_d  = 1'b0;
                    timer_d = timer_q;
                end
                CP0_COMPARE: begin
                    compare_d = cp0_wdata;
                    timer_d   = 1'b0;
                end
                CP0_STATUS: status_d = cp0_wdata;
                CP0_CAUSE:  ip_sw_d  = cp0_wdata[CA_IP_LO +: 2];
                CP0_EPC:    epc_d    = ADDR_W'(cp0_wdata);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            flush_q    <= 1'b0;
            redirect_q <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
            status_q   <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            exc_code_q <= '0;
            ip_sw_q    <= '0;
            bd_q       <= 1'b0;
            timer_q    <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            status_q   <= status_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            exc_code_q <= exc_code_d;
            ip_sw_q    <= ip_sw_d;
            bd_q       <= bd_d;
            timer_q    <= timer_d;
            tick_q     <= tick_d;
        end
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_BADVADDR: cp0_rdata = 32'(badvaddr_q);
            CP0_COUNT:    cp0_rdata = count_q;
            CP0_COMPARE:  cp0_rdata = compare_q;
            CP0_STATUS:   cp0_rdata = status_q;
            CP0_CAUSE:    cp0_rdata = cause;
            CP0_EPC:      cp0_rdata = 32'(epc_q);
            default: ;
        endcase
    end

    assign flush       = flush_q;
    assign redirect_pc = redirect_q;
    assign status_o    = status_q;
    assign cause_o     = cause;
    assign epc_o       = 32'(epc_q);

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: stimulus queues the expected flush-cycle state, a negedge
// monitor pops and compares it whenever the DUT flushes.
module tb_exc_ctrl;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_pc = '0;
    logic        mem_bd = 1'b0;
    logic [31:0] mem_badaddr = '0;
    logic [6:0]  exc_vec = '0;
    logic [5:0]  hw_int = '0;
    logic        cp0_we = 1'b0;
    logic [4:0]  cp0_addr = 5'd8;
    logic [31:0] cp0_wdata = '0;
    logic [31:0] cp0_rdata, excepttype, redirect_pc, status_o, cause_o, epc_o;
    logic        flush;

    exc_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .mem_valid  (mem_valid),
        .mem_pc     (mem_pc),
        .mem_bd     (mem_bd),
        .mem_badaddr(mem_badaddr),
        .exc_vec    (exc_vec),
        .hw_int     (hw_int),
        .cp0_we     (cp0_we),
        .cp0_addr   (cp0_addr),
        .cp0_wdata  (cp0_wdata),
        .cp0_rdata  (cp0_rdata),
        .excepttype (excepttype),
        .flush      (flush),
        .redirect_pc(redirect_pc),
        .status_o   (status_o),
        .cause_o    (cause_o),
        .epc_o      (epc_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] redirect;
        logic [31:0] epc;
        logic [31:0] bad;
        logic [4:0]  exc;
        logic        bd;
        logic        exl;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] redirect, input logic [31:0] epc,
                                input logic [4:0] exc, input logic bd, input logic exl,
                                input logic [31:0] bad);
        exp_t e;
        e.redirect = redirect;
        e.epc      = epc;
        e.bad      = bad;
        e.exc      = exc;
        e.bd       = bd;
        e.exl      = exl;
        return e;
    endfunction

    // cp0_addr idles at BadVAddr so the monitor can read it in every flush cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && flush) begin
            if (sb_q.size() == 0) begin
                check("unexpected_flush", 32'(flush), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("redirect_pc", redirect_pc, e.redirect);
                check("epc", epc_o, e.epc);
                check("cause_exccode", 32'(cause_o[6:2]), 32'(e.exc));
                check("cause_bd", 32'(cause_o[31]), 32'(e.bd));
                check("status_exl", 32'(status_o[1]), 32'(e.exl));
                check("badvaddr", cp0_rdata, e.bad);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        cp0_we    = 1'b1;
        cp0_addr  = addr;
        cp0_wdata = data;
        step();
        cp0_we   = 1'b0;
        cp0_addr = 5'd8;
    endtask

    task automatic issue(input logic [6:0] vec, input logic [31:0] pc, input logic bd,
                         input logic [31:0] bad, input logic [31:0] code, input exp_t e);
        mem_valid   = 1'b1;
        exc_vec     = vec;
        mem_pc      = pc;
        mem_bd      = bd;
        mem_badaddr = bad;
        #1 check("excepttype", excepttype, code);
        sb_q.push_back(e);
        step();
        mem_valid = 1'b0;
        exc_vec   = '0;
        mem_bd    = 1'b0;
        check("flush_rise", 32'(flush), 32'd1);
        step();
        check("flush_one_cycle", 32'(flush), 32'd0);
    endtask

    initial begin
        #1;
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_redirect", redirect_pc, 32'd0);
        check("rst_status", status_o, 32'd0);
        check("rst_cause", cause_o, 32'd0);
        check("rst_epc", epc_o, 32'd0);
        check("rst_badvaddr", cp0_rdata, 32'd0);
        #20 rst_n = 1'b1;
        step();

        // adel beats overflow; address is captured in BadVAddr
        issue(7'b1000001, 32'h8000_0010, 1'b0, 32'h1234_5679, 32'h04,
              mk(VEC, 32'h8000_0010, 5'd4, 1'b0, 1'b1, 32'h1234_5679));

        mtc0(5'd12, 32'h0000_0003);
        check("mtc0_status", status_o, 32'h0000_0003);

        // break while EXL=1, then reset lands in the flush cycle
        mem_valid = 1'b1;
        exc_vec   = 7'b0001000;
        mem_pc    = 32'h8000_0020;
        #1 check("excepttype_break", excepttype, 32'h09);
        sb_q.push_back(mk(VEC, 32'h8000_0010, 5'd9, 1'b0, 1'b1, 32'h1234_5679));
        step();
        mem_valid = 1'b0;
        exc_vec   = '0;
        @(negedge clk);
        #2;
        check("flush_before_reset", 32'(flush), 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_flush", 32'(flush), 32'd0);
        check("reset_status", status_o, 32'd0);
        check("reset_cause", cause_o, 32'd0);
        check("reset_epc", epc_o, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // delay-slot syscall, then eret back to the branch
        issue(7'b0000100, 32'h8000_0104, 1'b1, 32'hDEAD_BEEF, 32'h08,
              mk(VEC, 32'h8000_0100, 5'd8, 1'b1, 1'b1, 32'd0));
        issue(7'b0010000, 32'h8000_0108, 1'b0, 32'd0, 32'h0e,
              mk(32'h8000_0100, 32'h8000_0100, 5'd8, 1'b1, 1'b0, 32'd0));

        // hw_int[0] through the synchroniser into IP[2]
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001;
        step();
        check("ip2_after_1_edge", 32'(cause_o[10]), 32'd0);
        step();
        check("ip2_after_2_edges", 32'(cause_o[10]), 32'd1);
        issue(7'b0000000, 32'h8000_0200, 1'b0, 32'd0, 32'h01,
              mk(VEC, 32'h8000_0200, 5'd0, 1'b0, 1'b1, 32'd0));
        hw_int = '0;
        step();
        step();
        step();
        issue(7'b0010000, 32'h8000_0204, 1'b0, 32'd0, 32'h0e,
              mk(32'h8000_0200, 32'h8000_0200, 5'd0, 1'b0, 1'b0, 32'd0));

        // overflow held by stall for three cycles
        stall     = 1'b1;
        mem_valid = 1'b1;
        exc_vec   = 7'b1000000;
        mem_pc    = 32'h8000_0300;
        #1 check("excepttype_ov", excepttype, 32'h0c);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_no_flush", 32'(flush), 32'd0);
            check("stall_excepttype", excepttype, 32'h0c);
            check("stall_epc", epc_o, 32'h8000_0200);
        end
        stall = 1'b0;
        sb_q.push_back(mk(VEC, 32'h8000_0300, 5'd12, 1'b0, 1'b1, 32'd0));
        step();
        mem_valid = 1'b0;
        exc_vec   = '0;
        check("flush_after_stall", 32'(flush), 32'd1);
        step();
        check("flush_after_stall_drop", 32'(flush), 32'd0);

        // invalid while EXL=1 keeps the EPC
        issue(7'b0100000, 32'h8000_0400, 1'b0, 32'd0, 32'h0a,
              mk(VEC, 32'h8000_0300, 5'd10, 1'b0, 1'b1, 32'd0));

        // timer: Compare=4, Count=0 -> IP[7] on the 8th edge
        mtc0(5'd11, 32'd4);
        cp0_addr = 5'd11;
        #1 check("rdata_compare", cp0_rdata, 32'd4);
        cp0_addr = 5'd0;
        #1 check("rdata_unmapped", cp0_rdata, 32'd0);
        cp0_addr = 5'd8;
        mtc0(5'd9, 32'd0);
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 7) check("timer_not_yet", 32'(cause_o[15]), 32'd0);
            if (i == 8) check("timer_pending", 32'(cause_o[15]), 32'd1);
        end
        mtc0(5'd11, 32'd4);
        check("timer_cleared", 32'(cause_o[15]), 32'd0);

        step();
        step();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
